sipo_deserializer: RTL and testbench

//  Downstream consumer of the 4-bit parallel-in/serial-out shift stage.
//  - Samples the serial bit stream (LSB first), one bit per enabled cycle.
//  - Reassembles WIDTH-bit words and presents each word on a valid/ready output port.
//  - Flags overrun (word lost to a stalled sink) and framing errors (start during a word).

---
 rtl/sipo_deserializer_if.sv | 25 ++
 rtl/sipo_deserializer.sv | 96 +++++++++
 tb/tb_sipo_deserializer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// Serial-in / word-out bundle between a bit-serial source, the deserializer and its word sink.
// The master side drives the bit stream, ready and err_clr. The slave side returns words and flags.
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             sin;
    logic             bit_en;
    logic             start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic             frame_err;
    logic             err_clr;

    modport master (
        output sin, bit_en, start, dout_ready, err_clr,
        input  dout, dout_valid, overrun, frame_err
    );

    modport slave (
        input  sin, bit_en, start, dout_ready, err_clr,
        output dout, dout_valid, overrun, frame_err
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Reassembles WIDTH-bit words from a start-framed serial bit stream.
// Completed words go to a one-deep valid/ready output, with sticky overrun and framing flags.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input logic clk,
    input logic rst,
    sipo_deserializer_if.slave bus
);
    localparam int unsigned          CntW   = $clog2(WIDTH);
    localparam logic [CntW-1:0]      MaxCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             overrun_q;
    logic             frame_err_q;

    logic [CntW-1:0]  first_pos;
    logic [CntW-1:0]  wr_pos;
    logic [CntW-1:0]  last_pos;
    logic [WIDTH-1:0] word_full;
    logic             new_word;
    logic             last_bit;

    assign first_pos = LSB_FIRST ? '0 : MaxCnt;
    assign wr_pos    = LSB_FIRST ? cnt_q : MaxCnt - cnt_q;
    assign last_pos  = LSB_FIRST ? MaxCnt : '0;

    // The completed word includes the final bit being sampled at this same edge.
    always_comb begin
        word_full           = shreg_q;
        word_full[last_pos] = bus.sin;
    end

    assign new_word = bus.bit_en & bus.start;
    assign last_bit = bus.bit_en & ~bus.start & (state_q == StShift) & (cnt_q == MaxCnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (new_word) begin
                shreg_q            <= '0;
                shreg_q[first_pos] <= bus.sin;
                cnt_q              <= CntW'(1);
                state_q            <= StShift;
            end else if (bus.bit_en && state_q == StShift) begin
                shreg_q[wr_pos] <= bus.sin;
                if (cnt_q == MaxCnt) begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            if (last_bit) begin
                if (!valid_q || bus.dout_ready) begin
                    dout_q  <= word_full;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && bus.dout_ready) begin
                valid_q <= 1'b0;
            end

            // The clear comes first, so an error event at the same edge leaves its flag set.
            if (bus.err_clr) begin
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end
            if (last_bit && valid_q && !bus.dout_ready) begin
                overrun_q <= 1'b1;
            end
            if (new_word && state_q == StShift) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: directed cases on an LSB-first instance and an MSB-first instance.
// Random words go to the MSB-first instance. A scoreboard queue per instance holds expected words.
module tb_sipo_deserializer;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic sin_v[2];
    logic en_v[2];
    logic st_v[2];
    logic rdy_v[2];
    logic clr_v[2];

    sipo_deserializer_if #(.WIDTH(W)) ia ();
    sipo_deserializer_if #(.WIDTH(W)) ib ();

    assign ia.sin = sin_v[0];
    assign ia.bit_en = en_v[0];
    assign ia.start = st_v[0];
    assign ia.dout_ready = rdy_v[0];
    assign ia.err_clr = clr_v[0];
    assign ib.sin = sin_v[1];
    assign ib.bit_en = en_v[1];
    assign ib.start = st_v[1];
    assign ib.dout_ready = rdy_v[1];
    assign ib.err_clr = clr_v[1];

    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (.clk(clk), .rst(rst), .bus(ia.slave));
    sipo_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst(rst), .bus(ib.slave));

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives nbits bits of w, the first one with start. On the MSB-first instance, bit k is
    // taken from w[W-1-k], so w is always the word expected on dout.
    task automatic send(input int sel, input logic [W-1:0] w, input int nbits, input bit exp_out,
                        input int gap, input bit rdy_last);
        for (int k = 0; k < nbits; k++) begin
            for (int g = 0; g < gap; g++) begin
                en_v[sel] = 1'b0;
                st_v[sel] = 1'b0;
                tick();
            end
            sin_v[sel] = (sel == 1) ? w[W-1-k] : w[k];
            en_v[sel]  = 1'b1;
            st_v[sel]  = (k == 0);
            if (k == nbits - 1) begin
                if (exp_out) begin
                    if (sel == 1) q1.push_back(w);
                    else q0.push_back(w);
                end
                if (rdy_last) rdy_v[sel] = 1'b1;
            end
            tick();
            clr_v[sel] = 1'b0;
        end
        en_v[sel] = 1'b0;
        st_v[sel] = 1'b0;
    endtask

    // A handshake happens at the next posedge whenever valid and ready are both high at this negedge.
    always @(negedge clk) begin
        if (!rst && ia.dout_valid && ia.dout_ready) begin
            check_eq("sb0_nonempty", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) check_eq("sb0_word", 32'(ia.dout), 32'(q0.pop_front()));
        end
        if (!rst && ib.dout_valid && ib.dout_ready) begin
            check_eq("sb1_nonempty", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) check_eq("sb1_word", 32'(ib.dout), 32'(q1.pop_front()));
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            sin_v[i] = 1'b0; en_v[i] = 1'b0; st_v[i] = 1'b0; rdy_v[i] = 1'b0; clr_v[i] = 1'b0;
        end
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", 32'(ia.dout_valid), 0);
        check_eq("rst_dout", 32'(ia.dout), 0);
        check_eq("rst_overrun", 32'(ia.overrun), 0);
        check_eq("rst_frame", 32'(ia.frame_err), 0);

        // Bits 1,0,1,1 with the sink always ready.
        rdy_v[0] = 1'b1;
        send(0, 4'hD, 4, 1'b1, 0, 1'b0);
        check_eq("t1_valid", 32'(ia.dout_valid), 1);
        check_eq("t1_dout", 32'(ia.dout), 32'hD);
        tick();
        check_eq("t1_valid_drop", 32'(ia.dout_valid), 0);

        // The sink is stalled, so the second word is lost.
        rdy_v[0] = 1'b0;
        send(0, 4'h3, 4, 1'b1, 0, 1'b0);
        send(0, 4'h5, 4, 1'b0, 0, 1'b0);
        check_eq("t2_dout", 32'(ia.dout), 32'h3);
        check_eq("t2_overrun", 32'(ia.overrun), 1);
        check_eq("t2_valid", 32'(ia.dout_valid), 1);
        rdy_v[0] = 1'b1;
        tick();
        check_eq("t2_valid_drop", 32'(ia.dout_valid), 0);
        rdy_v[0] = 1'b0;
        clr_v[0] = 1'b1;
        tick();
        clr_v[0] = 1'b0;
        check_eq("t2_overrun_clr", 32'(ia.overrun), 0);

        // Ready rises at the edge where the second word completes.
        send(0, 4'h9, 4, 1'b1, 0, 1'b0);
        send(0, 4'h6, 4, 1'b1, 0, 1'b1);
        check_eq("t3_dout", 32'(ia.dout), 32'h6);
        check_eq("t3_valid", 32'(ia.dout_valid), 1);
        check_eq("t3_overrun", 32'(ia.overrun), 0);
        tick();
        check_eq("t3_valid_drop", 32'(ia.dout_valid), 0);

        // A start arrives mid-word, after two bits.
        send(0, 4'h3, 2, 1'b0, 0, 1'b0);
        send(0, 4'hA, 4, 1'b1, 0, 1'b0);
        check_eq("t4_frame", 32'(ia.frame_err), 1);
        check_eq("t4_dout", 32'(ia.dout), 32'hA);
        tick();
        clr_v[0] = 1'b1;
        tick();
        clr_v[0] = 1'b0;
        check_eq("t4_frame_clr", 32'(ia.frame_err), 0);
        // err_clr lands on the same edge as a new framing error, and the flag must stay set.
        send(0, 4'h1, 2, 1'b0, 0, 1'b0);
        clr_v[0] = 1'b1;
        send(0, 4'h5, 4, 1'b1, 0, 1'b0);
        check_eq("t4_set_wins", 32'(ia.frame_err), 1);
        check_eq("t4_dout2", 32'(ia.dout), 32'h5);
        tick();

        // Three idle cycles before each bit.
        send(0, 4'h6, 4, 1'b1, 3, 1'b0);
        check_eq("t5_dout", 32'(ia.dout), 32'h6);
        check_eq("t5_valid", 32'(ia.dout_valid), 1);
        tick();
        // Build up a pending word and both flags, then reset in the middle of a word.
        rdy_v[0] = 1'b0;
        send(0, 4'hC, 4, 1'b0, 0, 1'b0);
        send(0, 4'h1, 4, 1'b0, 0, 1'b0);
        send(0, 4'h7, 2, 1'b0, 0, 1'b0);
        send(0, 4'h7, 3, 1'b0, 0, 1'b0);
        check_eq("t5_pre_overrun", 32'(ia.overrun), 1);
        check_eq("t5_pre_frame", 32'(ia.frame_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5_rst_valid", 32'(ia.dout_valid), 0);
        check_eq("t5_rst_dout", 32'(ia.dout), 0);
        check_eq("t5_rst_overrun", 32'(ia.overrun), 0);
        check_eq("t5_rst_frame", 32'(ia.frame_err), 0);
        // The rest of the word is sent without a start and must be ignored.
        sin_v[0] = 1'b1;
        en_v[0] = 1'b1;
        tick();
        tick();
        en_v[0] = 1'b0;
        tick();
        check_eq("t5_no_word", 32'(ia.dout_valid), 0);

        // MSB-first instance: bits 1,0,0,0.
        rdy_v[1] = 1'b1;
        send(1, 4'h8, 4, 1'b1, 0, 1'b0);
        check_eq("t6_dout", 32'(ib.dout), 32'h8);
        check_eq("t6_valid", 32'(ib.dout_valid), 1);
        tick();
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] w;
            int gap;
            w   = W'($urandom_range(0, 15));
            gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 2));
            send(1, w, 4, 1'b1, gap, 1'b0);
        end
        tick();
        tick();
        tick();
        check_eq("t6_sb1_drained", 32'(q1.size()), 0);
        check_eq("t6_overrun", 32'(ib.overrun), 0);
        check_eq("sb0_drained", 32'(q0.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
